// File: rtl/pipe_pkg.sv
// Shared pipeline constants and the decoded-control bundle carried from ID to EX.
package pipe_pkg;

    localparam int XLEN    = 32;
    localparam int REG_AW  = 5;
    localparam int ALUOP_W = 4;

    typedef struct packed {
        logic               RegWrite;
        logic               MemRead;
        logic               MemWrite;
        logic               ALUSrc;
        logic               MemtoReg;
        logic               Branch;
        logic [ALUOP_W-1:0] ALUOp;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/operand_bypass.sv
// Write-back bypass for one register-file read port; x0 always reads as zero.
module operand_bypass
    import pipe_pkg::*;
(
    input  logic [REG_AW-1:0] rs,
    input  logic [XLEN-1:0]   rf_data,
    input  logic              wb_RegWrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic [XLEN-1:0]   op
);

    always_comb begin
        op = rf_data;
        if (rs == '0) begin
            op = '0;
        end else if (wb_RegWrite && (wb_rd == rs)) begin
            // The register file writes at the same edge we capture, so its read is stale.
            op = wb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB bypass, load-use bubble insertion, flush and hold.
// Optional macro ID_EX_STALL_COUNT_EN adds a saturating count of load-use bubbles.
module id_ex_stage
    import pipe_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic               id_valid,
    input  logic [XLEN-1:0]    id_pc,
    input  logic [XLEN-1:0]    id_imm,
    input  logic [REG_AW-1:0]  id_rs1,
    input  logic [REG_AW-1:0]  id_rs2,
    input  logic [REG_AW-1:0]  id_rd,
    input  logic [XLEN-1:0]    rf_data1,
    input  logic [XLEN-1:0]    rf_data2,
    input  logic               id_RegWrite,
    input  logic               id_MemRead,
    input  logic               id_MemWrite,
    input  logic               id_ALUSrc,
    input  logic               id_MemtoReg,
    input  logic               id_Branch,
    input  logic [ALUOP_W-1:0] id_ALUOp,
    input  logic               wb_RegWrite,
    input  logic [REG_AW-1:0]  wb_rd,
    input  logic [XLEN-1:0]    wb_data,
    input  logic               flush,
    input  logic               ex_hold,
    output logic               hazard_stall,
    output logic               ex_valid,
    output logic [XLEN-1:0]    ex_pc,
    output logic [XLEN-1:0]    ex_imm,
    output logic [XLEN-1:0]    ex_op1,
    output logic [XLEN-1:0]    ex_op2,
    output logic [REG_AW-1:0]  ex_rs1,
    output logic [REG_AW-1:0]  ex_rs2,
    output logic [REG_AW-1:0]  ex_rd,
    output logic               ex_RegWrite,
    output logic               ex_MemRead,
    output logic               ex_MemWrite,
    output logic               ex_ALUSrc,
    output logic               ex_MemtoReg,
    output logic               ex_Branch,
    output logic [ALUOP_W-1:0] ex_ALUOp
`ifdef ID_EX_STALL_COUNT_EN
    ,
    output logic [31:0]        bubble_count
`endif
);

    ctrl_t            id_ctrl;
    ctrl_t            ex_ctrl;
    logic [XLEN-1:0]  op1;
    logic [XLEN-1:0]  op2;
    logic             load_use;

    assign id_ctrl = '{RegWrite: id_RegWrite, MemRead: id_MemRead, MemWrite: id_MemWrite,
                       ALUSrc: id_ALUSrc, MemtoReg: id_MemtoReg, Branch: id_Branch,
                       ALUOp: id_ALUOp};

    operand_bypass u_bypass1 (
        .rs          (id_rs1),
        .rf_data     (rf_data1),
        .wb_RegWrite (wb_RegWrite),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .op          (op1)
    );

    operand_bypass u_bypass2 (
        .rs          (id_rs2),
        .rf_data     (rf_data2),
        .wb_RegWrite (wb_RegWrite),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .op          (op2)
    );

    assign load_use = id_valid && ex_valid && ex_ctrl.MemRead && (ex_rd != '0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    assign hazard_stall = !flush && (load_use || ex_hold);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= CTRL_NOP;
            ex_pc    <= '0;
            ex_imm   <= '0;
            ex_op1   <= '0;
            ex_op2   <= '0;
            ex_rs1   <= '0;
            ex_rs2   <= '0;
            ex_rd    <= '0;
        end else if (flush || (!ex_hold && load_use)) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= CTRL_NOP;
            ex_pc    <= '0;
            ex_imm   <= '0;
            ex_op1   <= '0;
            ex_op2   <= '0;
            ex_rs1   <= '0;
            ex_rs2   <= '0;
            ex_rd    <= '0;
        end else if (!ex_hold) begin
            ex_valid <= id_valid;
            ex_ctrl  <= id_valid ? id_ctrl : CTRL_NOP;
            ex_pc    <= id_pc;
            ex_imm   <= id_imm;
            ex_op1   <= op1;
            ex_op2   <= op2;
            ex_rs1   <= id_rs1;
            ex_rs2   <= id_rs2;
            ex_rd    <= id_rd;
        end
    end

    assign ex_RegWrite = ex_ctrl.RegWrite;
    assign ex_MemRead  = ex_ctrl.MemRead;
    assign ex_MemWrite = ex_ctrl.MemWrite;
    assign ex_ALUSrc   = ex_ctrl.ALUSrc;
    assign ex_MemtoReg = ex_ctrl.MemtoReg;
    assign ex_Branch   = ex_ctrl.Branch;
    assign ex_ALUOp    = ex_ctrl.ALUOp;

`ifdef ID_EX_STALL_COUNT_EN
    // Only load-use bubbles are counted; flush bubbles take priority and are excluded.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bubble_count <= '0;
        end else if (!flush && !ex_hold && load_use && (bubble_count != 32'hFFFF_FFFF)) begin
            bubble_count <= bubble_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: vector table plus hazard/hold/flush/reset sequences.
module tb_id_ex_stage;
    import pipe_pkg::*;

    logic               clock = 1'b0;
    logic               reset_n;
    logic               id_valid;
    logic [XLEN-1:0]    id_pc, id_imm, rf_data1, rf_data2, wb_data;
    logic [REG_AW-1:0]  id_rs1, id_rs2, id_rd, wb_rd;
    ctrl_t              id_c;
    logic               wb_RegWrite, flush, ex_hold;
    logic               hazard_stall, ex_valid;
    logic [XLEN-1:0]    ex_pc, ex_imm, ex_op1, ex_op2;
    logic [REG_AW-1:0]  ex_rs1, ex_rs2, ex_rd;
    logic               ex_RegWrite, ex_MemRead, ex_MemWrite, ex_ALUSrc, ex_MemtoReg, ex_Branch;
    logic [ALUOP_W-1:0] ex_ALUOp;
    ctrl_t              ex_c;
`ifdef ID_EX_STALL_COUNT_EN
    logic [31:0]        bubble_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    assign ex_c = '{RegWrite: ex_RegWrite, MemRead: ex_MemRead, MemWrite: ex_MemWrite,
                    ALUSrc: ex_ALUSrc, MemtoReg: ex_MemtoReg, Branch: ex_Branch, ALUOp: ex_ALUOp};

    id_ex_stage dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .id_valid     (id_valid),
        .id_pc        (id_pc),
        .id_imm       (id_imm),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .rf_data1     (rf_data1),
        .rf_data2     (rf_data2),
        .id_RegWrite  (id_c.RegWrite),
        .id_MemRead   (id_c.MemRead),
        .id_MemWrite  (id_c.MemWrite),
        .id_ALUSrc    (id_c.ALUSrc),
        .id_MemtoReg  (id_c.MemtoReg),
        .id_Branch    (id_c.Branch),
        .id_ALUOp     (id_c.ALUOp),
        .wb_RegWrite  (wb_RegWrite),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .flush        (flush),
        .ex_hold      (ex_hold),
        .hazard_stall (hazard_stall),
        .ex_valid     (ex_valid),
        .ex_pc        (ex_pc),
        .ex_imm       (ex_imm),
        .ex_op1       (ex_op1),
        .ex_op2       (ex_op2),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ex_rd        (ex_rd),
        .ex_RegWrite  (ex_RegWrite),
        .ex_MemRead   (ex_MemRead),
        .ex_MemWrite  (ex_MemWrite),
        .ex_ALUSrc    (ex_ALUSrc),
        .ex_MemtoReg  (ex_MemtoReg),
        .ex_Branch    (ex_Branch),
        .ex_ALUOp     (ex_ALUOp)
`ifdef ID_EX_STALL_COUNT_EN
        ,
        .bubble_count (bubble_count)
`endif
    );

    typedef struct {
        logic              valid;
        logic [XLEN-1:0]   pc, imm;
        logic [REG_AW-1:0] rs1, rs2, rd;
        logic [XLEN-1:0]   rf1, rf2;
        ctrl_t             c;
        logic              wbwe;
        logic [REG_AW-1:0] wbrd;
        logic [XLEN-1:0]   wbd;
        logic              exp_stall;
        logic [XLEN-1:0]   exp_op1, exp_op2;
        logic              exp_valid;
        ctrl_t             exp_c;
    } vec_t;

    vec_t  vec[9];
    ctrl_t c_add, c_lw, c_sw, c_br;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drive(input logic v, input logic [XLEN-1:0] pc, input logic [REG_AW-1:0] rs1,
                         input logic [REG_AW-1:0] rs2, input logic [REG_AW-1:0] rd,
                         input logic [XLEN-1:0] rf1, input ctrl_t c);
        id_valid = v;  id_pc = pc;  id_imm = 32'h0;
        id_rs1 = rs1;  id_rs2 = rs2;  id_rd = rd;
        rf_data1 = rf1;  rf_data2 = 32'h0;  id_c = c;
        wb_RegWrite = 1'b0;  wb_rd = '0;  wb_data = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        c_add = '{RegWrite: 1'b1, MemRead: 1'b0, MemWrite: 1'b0, ALUSrc: 1'b0, MemtoReg: 1'b0, Branch: 1'b0, ALUOp: 4'h2};
        c_lw  = '{RegWrite: 1'b1, MemRead: 1'b1, MemWrite: 1'b0, ALUSrc: 1'b1, MemtoReg: 1'b1, Branch: 1'b0, ALUOp: 4'h0};
        c_sw  = '{RegWrite: 1'b0, MemRead: 1'b0, MemWrite: 1'b1, ALUSrc: 1'b1, MemtoReg: 1'b0, Branch: 1'b0, ALUOp: 4'h0};
        c_br  = '{RegWrite: 1'b0, MemRead: 1'b0, MemWrite: 1'b0, ALUSrc: 1'b0, MemtoReg: 1'b0, Branch: 1'b1, ALUOp: 4'h6};

        //        valid pc        imm      rs1 rs2 rd  rf1        rf2        ctrl   wbwe wbrd wbd       stall op1        op2        v     ctrl
        vec[0] = '{1'b1, 32'h100, 32'h4,  5,  6,  7,  32'h11,    32'h22,    c_add, 1'b1, 5, 32'hDEAD, 1'b0, 32'hDEAD,  32'h22,    1'b1, c_add};
        vec[1] = '{1'b1, 32'h104, 32'h8,  0,  6,  7,  32'h11,    32'h22,    c_add, 1'b1, 0, 32'hDEAD, 1'b0, 32'h0,     32'h22,    1'b1, c_add};
        vec[2] = '{1'b1, 32'h108, 32'hC,  8,  9,  3,  32'hAAAA,  32'hBBBB,  c_lw,  1'b0, 8, 32'h1234, 1'b0, 32'hAAAA,  32'hBBBB,  1'b1, c_lw};
        vec[3] = '{1'b1, 32'h10C, 32'h10, 4,  5,  6,  32'h44,    32'h66,    c_sw,  1'b1, 5, 32'h55,   1'b0, 32'h44,    32'h55,    1'b1, c_sw};
        vec[4] = '{1'b0, 32'h110, 32'h0,  1,  3,  2,  32'h77,    32'h88,    c_add, 1'b0, 0, 32'h0,    1'b0, 32'h77,    32'h88,    1'b0, CTRL_NOP};
        vec[5] = '{1'b1, 32'h114, 32'h20, 2,  0,  9,  32'h2,     32'hFFFF,  c_br,  1'b1, 0, 32'h99,   1'b0, 32'h2,     32'h0,     1'b1, c_br};
        vec[6] = '{1'b1, 32'h118, 32'h0,  1,  2,  0,  32'h5,     32'h6,     c_lw,  1'b0, 0, 32'h0,    1'b0, 32'h5,     32'h6,     1'b1, c_lw};
        vec[7] = '{1'b1, 32'h11C, 32'h0,  0,  0,  4,  32'h7,     32'h8,     c_add, 1'b0, 0, 32'h0,    1'b0, 32'h0,     32'h0,     1'b1, c_add};
        vec[8] = '{1'b1, 32'h120, 32'h0,  9,  9,  1,  32'h1,     32'h2,     c_add, 1'b1, 9, 32'hCAFE, 1'b0, 32'hCAFE,  32'hCAFE,  1'b1, c_add};

        reset_n = 1'b0;  flush = 1'b0;  ex_hold = 1'b0;
        drive(1'b0, 32'h0, 0, 0, 0, 32'h0, CTRL_NOP);
        #12;
        chk("reset_valid", {63'd0, ex_valid}, 64'd0);
        chk("reset_ctrl", {54'd0, ex_c}, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            id_valid = vec[i].valid;  id_pc = vec[i].pc;  id_imm = vec[i].imm;
            id_rs1 = vec[i].rs1;  id_rs2 = vec[i].rs2;  id_rd = vec[i].rd;
            rf_data1 = vec[i].rf1;  rf_data2 = vec[i].rf2;  id_c = vec[i].c;
            wb_RegWrite = vec[i].wbwe;  wb_rd = vec[i].wbrd;  wb_data = vec[i].wbd;
            #1;
            chk($sformatf("v%0d_stall", i), {63'd0, hazard_stall}, {63'd0, vec[i].exp_stall});
            step();
            chk($sformatf("v%0d_valid", i), {63'd0, ex_valid}, {63'd0, vec[i].exp_valid});
            chk($sformatf("v%0d_ctrl", i), {54'd0, ex_c}, {54'd0, vec[i].exp_c});
            chk($sformatf("v%0d_ops", i), {ex_op1, ex_op2}, {vec[i].exp_op1, vec[i].exp_op2});
            chk($sformatf("v%0d_pc_imm", i), {ex_pc, ex_imm}, {vec[i].pc, vec[i].imm});
            chk($sformatf("v%0d_idx", i), {49'd0, ex_rs1, ex_rs2, ex_rd},
                {49'd0, vec[i].rs1, vec[i].rs2, vec[i].rd});
        end

        // Load-use: lw x3 then add reading x3 through rs2.
        drive(1'b1, 32'h1F0, 1, 2, 3, 32'h0, c_lw);
        step();
        drive(1'b1, 32'h200, 4, 3, 5, 32'h40, c_add);
        #1;
        chk("lu_stall", {63'd0, hazard_stall}, 64'd1);
        step();
        chk("lu_bubble_valid", {63'd0, ex_valid}, 64'd0);
        chk("lu_bubble_ctrl", {54'd0, ex_c}, 64'd0);
        chk("lu_no_restall", {63'd0, hazard_stall}, 64'd0);
        step();
        chk("lu_capture", {31'd0, ex_valid, ex_pc}, {31'd0, 1'b1, 32'h200});
        chk("lu_capture_rw", {63'd0, ex_RegWrite}, 64'd1);
        chk("lu_after_stall", {63'd0, hazard_stall}, 64'd0);

        // Hold: EX contents frozen for three cycles while ID changes.
        drive(1'b1, 32'h300, 1, 0, 6, 32'h31, c_add);
        step();
        ex_hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h400 + 32'(k), 2, 0, 7, 32'h90 + 32'(k), c_sw);
            #1;
            chk($sformatf("hold%0d_stall", k), {63'd0, hazard_stall}, 64'd1);
            step();
            chk($sformatf("hold%0d_regs", k), {ex_pc, ex_op1}, {32'h300, 32'h31});
            chk($sformatf("hold%0d_ctrl", k), {54'd0, ex_c}, {54'd0, c_add});
        end
        ex_hold = 1'b0;

        // Flush beats hold and a pending load-use hazard.
        drive(1'b1, 32'h500, 1, 2, 3, 32'h0, c_lw);
        step();
        drive(1'b1, 32'h504, 3, 0, 8, 32'h0, c_add);
        ex_hold = 1'b1;  flush = 1'b1;
        #1;
        chk("flush_stall", {63'd0, hazard_stall}, 64'd0);
        step();
        chk("flush_valid_rw", {62'd0, ex_valid, ex_RegWrite}, 64'd0);
        chk("flush_clear_pc", {32'd0, ex_pc}, 64'd0);
        ex_hold = 1'b0;  flush = 1'b0;

        // Asynchronous reset discards a live instruction without a clock edge.
        drive(1'b1, 32'h600, 1, 2, 9, 32'h61, c_add);
        step();
        chk("prerst_valid", {63'd0, ex_valid}, 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_async_valid", {63'd0, ex_valid}, 64'd0);
        chk("rst_async_fields", {ex_pc, ex_op1}, 64'd0);
        chk("rst_async_ctrl", {44'd0, ex_c, ex_rd, ex_rs1}, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;

`ifdef ID_EX_STALL_COUNT_EN
        chk("cnt_reset", {32'd0, bubble_count}, 64'd0);
        for (int n = 0; n < 4; n++) begin
            drive(1'b1, 32'h700, 1, 2, 3, 32'h0, c_lw);
            step();
            drive(1'b1, 32'h704, 3, 4, 5, 32'h0, c_add);
            step();
            step();
        end
        for (int n = 0; n < 2; n++) begin
            drive(1'b1, 32'h800, 1, 2, 3, 32'h0, c_lw);
            step();
            drive(1'b1, 32'h804, 3, 4, 5, 32'h0, c_add);
            flush = 1'b1;
            step();
            flush = 1'b0;
        end
        chk("cnt_value", {32'd0, bubble_count}, 64'd4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register that sits directly downstream of the register file.
- Captures decoded control, immediate, PC, register indices and the two register-file read operands, and presents them registered to the EX stage.
- Provides a write-back bypass, because the register file writes at posedge and reads combinationally, so a same-cycle read returns the old value.
- Detects load-use hazards and inserts bubbles; supports flush and downstream hold.

Parameters:
XLEN, 32, datapath width
REG_AW, 5, register index width (32 registers, x0 hardwired zero)
ALUOP_W, 4, ALU operation code width

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_pc  in  XLEN  instruction PC
id_imm  in  XLEN  sign-extended immediate
id_rs1, id_rs2, id_rd  in  REG_AW  register indices
rf_data1, rf_data2  in  XLEN  register file read_data1/read_data2
id_RegWrite, id_MemRead, id_MemWrite, id_ALUSrc, id_MemtoReg, id_Branch  in  1  decoded control
id_ALUOp  in  ALUOP_W  decoded ALU op
wb_RegWrite  in  1  WB writes this cycle
wb_rd  in  REG_AW  WB destination
wb_data  in  XLEN  WB value
flush  in  1  branch taken/redirect: kill the instruction entering EX
ex_hold  in  1  downstream busy: freeze EX contents
hazard_stall  out  1  combinational: IF and ID must hold this cycle
ex_valid  out  1  EX holds a real instruction
ex_pc, ex_imm, ex_op1, ex_op2  out  XLEN  registered fields/operands
ex_rs1, ex_rs2, ex_rd  out  REG_AW  registered indices
ex_RegWrite, ex_MemRead, ex_MemWrite, ex_ALUSrc, ex_MemtoReg, ex_Branch  out  1  registered control
ex_ALUOp  out  ALUOP_W  registered ALU op

Behaviour:
- Clocking and reset:
  - Single clock domain; clock rising edge; reset_n asynchronous, active-low.
  - Reset: every ex_* output and ex_valid = 0 (NOP bubble).
  - Reset mid-operation discards the held instruction immediately.
- Bypass (combinational, per source s in {1,2}):
  - op_s = wb_data if wb_RegWrite && wb_rd!=0 && wb_rd==id_rs_s; otherwise rf_data_s.
  - id_rs_s==0 always yields 0, regardless of wb inputs.
- Load-use hazard:
  - hazard_stall = id_valid && ex_valid && ex_MemRead && ex_rd!=0 && (ex_rd==id_rs1 || ex_rd==id_rs2).
  - hazard_stall is also 1 whenever ex_hold=1 && flush=0.
  - hazard_stall is forced 0 when flush=1.
- Update priority at each posedge (highest first):
  1. flush: load bubble. ex_valid=0 and all control outputs 0. Data fields are don't-care but are cleared to 0.
  2. ex_hold: all ex_* registers keep their values.
  3. load-use hazard: load bubble (as flush). ID holds, so the same instruction is re-presented next cycle.
  4. Otherwise capture: ex_* <= id_* / op_s; ex_valid <= id_valid.
- Bubble handling:
  - id_valid=0 captures a bubble; control outputs are gated to 0 whenever the captured valid is 0.
- Latency and hazard spacing:
  - Latency is 1 cycle from ID to EX.
  - A load followed by a dependent instruction costs exactly 1 bubble.
  - After the bubble, the load has advanced and is no longer in EX, so no repeat stall occurs.
- Boundary conditions:
  - A load with rd=x0 never stalls.
  - A simultaneous WB write to the same rd as id_rs_s: bypass supplies the new value, never the stale one.
  - flush and ex_hold together: flush wins.

Optional Feature:
- Macro: ID_EX_STALL_COUNT_EN
- Defined:
  - Adds output bubble_count (32-bit).
  - Increments by 1 on every posedge that loads a hazard bubble; flush bubbles are not counted.
  - Saturates at 0xFFFFFFFF.
  - Reset to 0.
- Undefined: port and logic absent; behaviour is otherwise identical.

Decomposition:
- Package pipe_pkg:
  - XLEN, REG_AW, ALUOP_W constants.
  - typedef ctrl_t: packed struct of RegWrite, MemRead, MemWrite, ALUSrc, MemtoReg, Branch, ALUOp.
  - Constant CTRL_NOP (all zero).
- Sub-module operand_bypass:
  - Combinational; instantiated twice (rs1, rs2).
  - Inputs: rs, rf_data, wb_RegWrite, wb_rd, wb_data.
  - Output: op.

Test Plan:
- Reset: assert reset_n=0 mid-stream with ex_valid=1 -> all ex_* outputs 0 immediately, without waiting for a clock edge.
- WB bypass: rf_data1=0x11, wb_RegWrite=1, wb_rd=5, id_rs1=5, wb_data=0xDEAD -> next cycle ex_op1=0xDEAD. Same stimulus with wb_rd=0 and id_rs1=0 -> ex_op1=0.
- Load-use: lw x3 in EX (ex_MemRead=1, ex_rd=3), ID add with rs2=3 -> hazard_stall=1, next cycle ex_valid=0. Following cycle the add is captured and hazard_stall=0.
- Flush priority: flush=1 with ex_hold=1 and a hazard present -> ex_valid=0, ex_RegWrite=0, hazard_stall=0.
- Hold: ex_hold=1 for 3 cycles while id_* changes -> ex_* stable with its original values, hazard_stall=1 throughout.
- ID_EX_STALL_COUNT_EN: 4 load-use bubbles plus 2 flushes -> bubble_count=4.
